prefetch_unit: RTL and testbench
================================

# prefetch_unit

Parametrised instruction-fetch front end that replaces the single-register PC fetch stage. It generates sequential PCs, issues requests to the instruction memory over a valid/ready handshake, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode consumes the FIFO through a valid/ready handshake. A branch redirect flushes the FIFO, discards stale in-flight responses and restarts fetch at the target.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 0, PC loaded on reset; must be 4-byte aligned
- DEPTH, 2, FIFO entries and maximum outstanding requests (>=1)

- i_clk  in  1  clock, rising-edge
- i_rst  in  1  reset, asynchronous, active-high
- i_branch  in  1  redirect pulse, sampled each cycle
- i_addr  in  XLEN  redirect target; bits [1:0] are forced to 0
- o_imem_req_valid  out  1  fetch request valid
- o_imem_req_addr  out  XLEN  fetch address (current PC)
- i_imem_req_ready  in  1  memory accepts request
- i_imem_rsp_valid  in  1  in-order response valid, 1 per request, no backpressure
- i_imem_rsp_data  in  XLEN  fetched instruction
- o_inst_valid  out  1  FIFO head valid
- o_inst  out  XLEN  head instruction
- o_inst_pc  out  XLEN  head PC
- i_inst_ready  in  1  decode accepts head

## Operation
- State:
  - pc (XLEN): next request address.
  - rsp_pc (XLEN): PC of the next non-dropped response.
  - inflight, drop_cnt, count: each clog2(DEPTH+1) bits.
  - FIFO of {inst, pc} with head/tail pointers that wrap modulo DEPTH.
- Credit: o_imem_req_valid = !i_rst && !i_branch && (count + inflight + drop_cnt < DEPTH). o_imem_req_addr = pc.
- Request fire (valid && ready): pc <= pc + 4, wrapping modulo 2^XLEN. inflight increments.
- Response, drop_cnt > 0: the response is discarded and drop_cnt decrements.
- Response, drop_cnt == 0, inflight > 0: push {i_imem_rsp_data, rsp_pc}; rsp_pc += 4; inflight decrements.
- Response with inflight == drop_cnt == 0: protocol violation, ignored, no state change.
- Pop: on o_inst_valid && i_inst_ready, the head advances. o_inst_valid = (count != 0). o_inst and o_inst_pc come from the FIFO head register.
- Push and pop in the same cycle are allowed, including when count == DEPTH.
- Redirect (i_branch = 1) has priority over every other event in that cycle:
  - pc <= target; rsp_pc <= target (target = {i_addr[XLEN-1:2], 2'b00}).
  - FIFO cleared: count = 0, pointers = 0.
  - drop_cnt <= drop_cnt + inflight − (1 if i_imem_rsp_valid that cycle else 0); inflight <= 0.
  - No request is issued. Any pop that cycle is irrelevant, since the FIFO is cleared.
- Back-to-back redirects: each one re-applies the rule above; the last target wins.
- Reset: pc = rsp_pc = RESET_PC; inflight = drop_cnt = count = 0; pointers = 0.
  - Outputs: o_imem_req_valid = 0, o_imem_req_addr = RESET_PC, o_inst_valid = 0, o_inst = 0, o_inst_pc = 0.
  - Reset mid-operation abandons all outstanding requests. The memory is reset with the same i_rst.

## Timing
- First request: o_imem_req_valid rises in the first cycle with i_rst low, combinationally from registered state.
- Sustained throughput is 1 request/cycle with memory ready every cycle.
- Response in cycle M gives o_inst_valid in cycle M+1; the FIFO has no bypass.
- Redirect in cycle N:
  - o_inst_valid = 0 and o_imem_req_addr = target in cycle N+1.
  - The request is valid in N+1 if credit allows (count + inflight + drop_cnt < DEPTH).
- Stalled decode (i_inst_ready = 0): the FIFO fills. Request valid drops once count + inflight == DEPTH and is never overrun.
- Counters never exceed DEPTH; the FIFO never overflows.

## Test plan
- Reset release, RESET_PC = 0, memory always ready, 1-cycle response latency, decode always ready: request addresses 0, 4, 8, 12 on consecutive cycles; o_inst_pc sequence 0, 4, 8, 12 with matching data.
- Decode stalled, DEPTH = 2: exactly 2 requests issue (0, 4) and then o_imem_req_valid stays 0. After i_inst_ready = 1 for 1 cycle, one new request to 8 issues.
- Redirect with 2 requests in flight, i_addr = 32'h000000FF: req_addr = 32'h000000FC the next cycle. Both stale responses are dropped; the first delivered o_inst_pc is 32'h000000FC.
- Redirect in the same cycle as a response: that response is discarded. drop_cnt = inflight − 1, and the target's instruction is delivered first.
- pc = 32'hFFFFFFFC with sequential fetch: the next request is 32'h00000000 (wrap).
- Assert i_rst mid-stream with the FIFO full: all outputs go to reset values immediately (asynchronous). After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/prefetch_unit.sv
// prefetch_unit: instruction-fetch front end.
// Issues sequential fetch requests under a credit limit. Returned instructions
// are buffered with their PCs in a small FIFO that decode drains. A branch
// redirect flushes the FIFO, marks in-flight responses as stale and restarts
// fetch at the target.
//
// Handshake semantics (both request and decode sides): a transfer happens in
// a cycle where valid and ready are both high at the rising clock edge. Valid
// never depends on ready. Memory responses have no backpressure and arrive
// in request order, one per accepted request.
module prefetch_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = {XLEN{1'b0}},
  parameter int                DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_branch,
  input  logic [XLEN-1:0] i_addr,
  output logic            o_imem_req_valid,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_req_ready,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  input  logic            i_inst_ready
);

  // Counter width holds 0..DEPTH. Sums of three counters use two extra bits.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Fetch and response-tracking state.
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [XLEN-1:0] r_fifo_inst [DEPTH];
  logic [XLEN-1:0] r_fifo_pc   [DEPTH];

  // Combinational event decode.
  logic [XLEN-1:0] w_target;
  logic [SW-1:0]   w_occupancy;
  logic            w_credit;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_rsp_push;
  logic            w_pop;
  logic            w_rsp_any_owed;

  // Next-state values for the counters.
  logic [CW-1:0]   w_inflight_nxt;
  logic [CW-1:0]   w_drop_cnt_nxt;
  logic [CW-1:0]   w_count_nxt;

  // Wrap a FIFO pointer modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end
    return p + PW'(1);
  endfunction

  // Redirect targets are forced to word alignment.
  assign w_target = i_addr & ~(XLEN'(3));

  // Every buffered entry, outstanding request and stale response holds a
  // slot; a new request is allowed only while a slot is free.
  assign w_occupancy = SW'(r_count) + SW'(r_inflight) + SW'(r_drop_cnt);
  assign w_credit    = (w_occupancy < SW'(DEPTH));
  assign w_req_valid = !i_rst && !i_branch && w_credit;
  assign w_req_fire  = w_req_valid && i_imem_req_ready;

  // Stale responses are consumed first; a response with nothing owed is
  // a protocol violation and is simply ignored.
  assign w_rsp_drop     = i_imem_rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_push     = i_imem_rsp_valid && (r_drop_cnt == '0) && (r_inflight != '0);
  assign w_rsp_any_owed = (r_drop_cnt != '0) || (r_inflight != '0);
  assign w_pop          = (r_count != '0) && i_inst_ready;

  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = r_pc;
  assign o_inst_valid     = (r_count != '0);
  assign o_inst           = r_fifo_inst[r_head];
  assign o_inst_pc        = r_fifo_pc[r_head];

  // Counter next-state: a redirect moves everything in flight to the drop
  // count (minus a response arriving in that same cycle) and empties the FIFO.
  always_comb begin
    w_inflight_nxt = r_inflight;
    w_drop_cnt_nxt = r_drop_cnt;
    w_count_nxt    = r_count;
    if (i_branch) begin
      w_inflight_nxt = '0;
      w_count_nxt    = '0;
      w_drop_cnt_nxt = r_drop_cnt + r_inflight
                       - CW'(i_imem_rsp_valid && w_rsp_any_owed);
    end else begin
      w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(w_rsp_push);
      w_drop_cnt_nxt = r_drop_cnt - CW'(w_rsp_drop);
      w_count_nxt    = r_count + CW'(w_rsp_push) - CW'(w_pop);
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
      r_count    <= w_count_nxt;
    end
  end

  // Request PC and the PC tagged onto the next accepted response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
    end else if (i_branch) begin
      r_pc     <= w_target;
      r_rsp_pc <= w_target;
    end else begin
      if (w_req_fire) begin
        r_pc <= r_pc + XLEN'(4);
      end
      if (w_rsp_push) begin
        r_rsp_pc <= r_rsp_pc + XLEN'(4);
      end
    end
  end

  // FIFO pointers: cleared on redirect, advanced on push and pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (i_branch) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_rsp_push) begin
        r_tail <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
    end
  end

  // FIFO storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_inst[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (w_rsp_push && !i_branch) begin
      r_fifo_inst[r_tail] <= i_imem_rsp_data;
      r_fifo_pc[r_tail]   <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed scenarios followed by a random phase,
// checked against a transaction-level model (pending requests tagged stale on
// redirect, and an expected queue of PCs waiting for decode).
module tb_prefetch_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        i_rst;
  logic        i_branch;
  logic [31:0] i_addr;
  logic        o_imem_req_valid;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_req_ready;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;

  prefetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_branch         (i_branch),
    .i_addr           (i_addr),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model state.
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  pend_t       pend_q[$];   // requests accepted by memory, not yet answered
  logic [31:0] exp_q[$];    // PCs buffered for decode, in delivery order
  logic [31:0] m_pc;        // address of the next request
  logic [31:0] fire_log[$];
  logic [31:0] pop_log[$];
  int          n_pass;
  int          n_fail;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hC3A5} + 32'h0101_0000;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hDEAD_BEEF;
  endfunction

  // Scoreboard comparison.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle, entered just after a falling edge: drive inputs,
  // check outputs against the model, advance the model, wait a cycle.
  task automatic cycle(input bit br, input logic [31:0] addr, input bit mem_rdy,
                       input bit dec_rdy, input bit rsp_en);
    bit    rsp;
    bit    exp_rv;
    bit    fire;
    bit    pop;
    pend_t h;
    i_branch         = br;
    i_addr           = addr;
    i_imem_req_ready = mem_rdy;
    i_inst_ready     = dec_rdy;
    rsp              = rsp_en && (pend_q.size() > 0);
    i_imem_rsp_valid = rsp;
    i_imem_rsp_data  = rsp ? mem_word(pend_q[0].addr) : $urandom();
    #1;
    exp_rv = !br && ((pend_q.size() + exp_q.size()) < DEPTH);
    chk("req_valid", {31'b0, o_imem_req_valid}, {31'b0, exp_rv});
    chk("req_addr", o_imem_req_addr, m_pc);
    chk("inst_valid", {31'b0, o_inst_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("inst_pc", o_inst_pc, exp_q[0]);
      chk("inst", o_inst, mem_word(exp_q[0]));
    end
    fire = exp_rv && mem_rdy;
    pop  = (exp_q.size() != 0) && dec_rdy;
    if (br) begin
      if (rsp) void'(pend_q.pop_front());
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      exp_q.delete();
      m_pc = {addr[31:2], 2'b00};
    end else begin
      if (pop) pop_log.push_back(exp_q.pop_front());
      if (rsp) begin
        h = pend_q.pop_front();
        if (!h.stale) exp_q.push_back(h.addr);
      end
      if (fire) begin
        pend_q.push_back('{addr: m_pc, stale: 1'b0});
        fire_log.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset (asynchronously), check outputs at once, release at a
  // falling edge two rising edges later. The memory is reset alongside.
  task automatic do_reset();
    i_rst            = 1'b1;
    i_branch         = 1'b0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_inst_ready     = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, o_imem_req_valid}, 32'd0);
    chk("rst_req_addr", o_imem_req_addr, RESET_PC);
    chk("rst_inst_valid", {31'b0, o_inst_valid}, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_inst_pc", o_inst_pc, 32'd0);
    pend_q.delete();
    exp_q.delete();
    fire_log.delete();
    pop_log.delete();
    m_pc = RESET_PC;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  // Run normal cycles until decode takes an instruction, bounded.
  task automatic wait_first_pop(input string tag, input logic [31:0] exp_pc);
    pop_log.delete();
    for (int n = 0; n < 20 && pop_log.size() == 0; n++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk({tag, "_delivered"}, {31'b0, pop_log.size() != 0}, 32'd1);
    chk(tag, q_at(pop_log, 0), exp_pc);
  endtask

  initial begin
    n_pass           = 0;
    n_fail           = 0;
    i_rst            = 1'b0;
    i_branch         = 1'b0;
    i_addr           = '0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_inst_ready     = 1'b0;
    m_pc             = RESET_PC;
    #2;

    // Sequential fetch with 1-cycle memory and ready decode.
    do_reset();
    repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("seq_req_addr", q_at(fire_log, i), 32'(i * 4));
      chk("seq_pop_pc", q_at(pop_log, i), 32'(i * 4));
    end

    // Decode stalled: two requests, then nothing until a slot frees.
    do_reset();
    repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("stall_req_count", fire_log.size(), 32'd2);
    chk("stall_req0", q_at(fire_log, 0), 32'h0);
    chk("stall_req1", q_at(fire_log, 1), 32'h4);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("stall_resume_count", fire_log.size(), 32'd3);
    chk("stall_resume_addr", q_at(fire_log, 2), 32'h8);

    // Redirect with two requests in flight, unaligned target.
    do_reset();
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_00FF, 1'b1, 1'b1, 1'b0);
    chk("redir_addr", o_imem_req_addr, 32'h0000_00FC);
    chk("redir_inst_valid", {31'b0, o_inst_valid}, 32'd0);
    wait_first_pop("redir_first_pc", 32'h0000_00FC);

    // Redirect coinciding with a response.
    do_reset();
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0040, 1'b1, 1'b1, 1'b1);
    wait_first_pop("redir_rsp_first_pc", 32'h0000_0040);

    // PC wraps past the top of the address space.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1);
    fire_log.delete();
    repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("wrap_req0", q_at(fire_log, 0), 32'hFFFF_FFFC);
    chk("wrap_req1", q_at(fire_log, 1), 32'h0000_0000);

    // Reset mid-stream with the FIFO full, then restart.
    repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("full_before_rst", {31'b0, o_inst_valid}, 32'd1);
    #2;
    do_reset();
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("post_rst_req0", q_at(fire_log, 0), RESET_PC);

    // Random traffic: redirects, memory stalls, decode stalls, latency.
    for (int n = 0; n < 2000; n++) begin
      cycle($urandom_range(0, 19) == 0, $urandom(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
